ram_responder: RTL and testbench
================================

# ram_responder

Memory-side responder for the core's data-memory port. It accepts one load or store request at a time over a valid/ready handshake. It then inserts a configurable number of wait states and returns a single response. Loads return data aligned and sign- or zero-extended per RV32I `funct3`; stores perform byte-lane merges. Writes above a fixed boundary are forwarded to a one-cycle MMIO strobe that feeds the VGA side.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the internal array (power of two).
- `LATENCY`, 2: wait states between request acceptance and response (0–15).
- `MMIO_BASE`, 32'h0001_0000: byte addresses at or above this go to MMIO.
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `req_funct3` in 3: RV32I load/store width code.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: core accepts response.
- `resp_rdata` out 32: load result, extended; 0 for stores and errors.
- `resp_error` out 1: misaligned, out-of-range, or illegal `funct3`.
- `mmio_valid` out 1: one-cycle MMIO write strobe.
- `mmio_addr` out 32: MMIO byte address.
- `mmio_wdata` out 32: MMIO store data, right-aligned.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - `req_valid`=1 latches addr, wdata, funct3 and write.
  - Goes to WAIT when `LATENCY`>0, otherwise to RESP; wait counter loaded with `LATENCY`.
- WAIT: `req_ready`=0; counter decrements each cycle; at 1, goes to RESP.
- Entry to RESP computes the result, commits any store, and raises `resp_valid`.
- RESP: `resp_valid`, `resp_rdata` and `resp_error` are held stable until `resp_ready`=1, then the FSM returns to IDLE.
- Load codes: LB=000, LH=001, LW=010, LBU=100, LHU=101. Store codes: SB=000, SH=001, SW=010. Any other code sets `resp_error` with no side effects.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0. A violation sets error and drops the store.
- RAM region:
  - addr < `MMIO_BASE` and addr[31:2] < `DEPTH`; word index = addr[31:2].
  - Below `MMIO_BASE` but beyond `DEPTH` gives an error.
- Loads: select the lane by addr[1:0]; LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Stores: read-modify-write of the addressed lanes only; the other bytes are unchanged.
- MMIO region:
  - A store pulses `mmio_valid` for exactly one cycle on RESP entry, with the latched addr and wdata, and returns no error.
  - A load returns 0 with no error.
- Array contents are initialised to 0 at time zero and are not cleared by `rst`.

## Timing
- Reset values: FSM=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `mmio_valid`=0, `mmio_addr`=0, `mmio_wdata`=0.
- Response latency: `resp_valid` rises `LATENCY`+1 cycles after the accepting edge. With `LATENCY`=0, it rises the next cycle.
- Throughput: one request per `LATENCY`+2 cycles, because IDLE is always visited between transactions (no back-to-back acceptance).
- Load-after-store to the same word always sees the stored data, since the store commits before the next request is accepted.
- `rst` asserted in WAIT or RESP aborts the transaction: no store commit, no MMIO strobe, and outputs return to reset values next cycle.
- `rst` has priority over every other input in the same cycle.
- Request inputs are ignored outside IDLE.

## Structure
- Shared package `mem_pkg`: funct3 load/store constants, FSM state enum, `MMIO_BASE` default.
- Sub-module `lane_align`, purely combinational:
  - Load side: (word, addr[1:0], funct3) to extended rdata.
  - Store side: (old word, wdata, addr[1:0], funct3) to merged word plus misalignment flag.
- The responder holds the FSM, counter, array and MMIO register.

## Test plan
- `LATENCY`=2, SW 0xDEADBEEF at 0x10 then LW 0x10 -> each `resp_valid` rises 3 cycles after acceptance; rdata=0xDEADBEEF.
- SB 0x7F at 0x11 over 0xDEADBEEF, then LB 0x11, LBU 0x13, LH 0x12 -> word 0xDEAD7FEF; LB=0x0000007F, LBU=0x000000DE, LH=0xFFFFDEAD.
- LW at 0x2, SH at 0x5, LW at `DEPTH`*4 -> `resp_error`=1 and rdata=0 for all three; the memory word at 0x4 is unchanged.
- SW 0x00000041 at 0x00010004 -> `mmio_valid` for exactly one cycle with addr 0x00010004 and wdata 0x41; no error; a following LW at the same address returns 0.
- `resp_ready` held low for 5 cycles in RESP -> outputs stay stable and `req_ready`=0 throughout; release returns to IDLE next cycle.
- `rst` pulsed during WAIT of SW 0x12345678 at 0x20 -> outputs at reset values next cycle; LW 0x20 afterwards returns the prior value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: RV32I width codes,
// responder FSM states and the default MMIO boundary.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Stores only have B/H/W; loads additionally have the unsigned B/H forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store)
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane logic: extends a lane of a memory word for loads
// and merges store data into the old word, flagging misaligned accesses.
module lane_align
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata,
  output logic [31:0] o_merged,
  output logic        o_misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_be;
  logic [31:0] w_wlanes;

  assign w_byte = i_word[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_rdata = '0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_rdata = {24'b0, w_byte};
      F3_H:    o_rdata = {{16{w_half[15]}}, w_half};
      F3_HU:   o_rdata = {16'b0, w_half};
      F3_W:    o_rdata = i_word;
      default: o_rdata = '0;
    endcase
  end

  // funct3[1:0] encodes the access size for both loads and stores.
  always_comb begin
    o_misaligned = 1'b0;
    w_be         = 4'b1111;
    w_wlanes     = i_wdata;
    case (i_funct3[1:0])
      2'b00: begin
        w_be     = 4'b0001 << i_off;
        w_wlanes = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        o_misaligned = i_off[0];
        w_be         = i_off[1] ? 4'b1100 : 4'b0011;
        w_wlanes     = {2{i_wdata[15:0]}};
      end
      default: begin
        o_misaligned = (i_off != 2'b00);
        w_be         = 4'b1111;
        w_wlanes     = i_wdata;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_merged[8*gi +: 8] = w_be[gi] ? w_wlanes[8*gi +: 8] : i_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/ram_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a
// held response. RAM below MMIO_BASE, one-cycle write strobe at or above it.
module ram_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        mmio_valid,
  output logic [31:0] mmio_addr,
  output logic [31:0] mmio_wdata
);

  localparam int         IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_write;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;
  logic        r_mmio_valid;
  logic [31:0] r_mmio_addr;
  logic [31:0] r_mmio_wdata;
  logic [31:0] r_rd_word;
  logic [31:0] r_mem [DEPTH] = '{default: '0};

  logic        w_accept;
  logic        w_compute;
  logic        w_is_mmio;
  logic        w_oor;
  logic        w_misaligned;
  logic        w_err;
  logic        w_commit;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;

  assign w_accept  = (r_state == ST_IDLE) && req_valid;
  // First RESP cycle evaluates the latched request; later cycles just hold.
  assign w_compute = (r_state == ST_RESP) && !r_resp_valid;
  assign w_is_mmio = (r_addr >= MMIO_BASE);
  assign w_oor     = !w_is_mmio && (r_addr[31:2] >= 30'(DEPTH));
  assign w_err     = !f3_legal(r_write, r_funct3) || w_misaligned || w_oor;
  assign w_commit  = w_compute && r_write && !w_is_mmio && !w_err && !rst;

  lane_align u_lane_align (
    .i_word       (r_rd_word),
    .i_wdata      (r_wdata),
    .i_off        (r_addr[1:0]),
    .i_funct3     (r_funct3),
    .o_rdata      (w_load_data),
    .o_merged     (w_merged),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = (LAT != 4'd0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (r_cnt == 4'd1) w_state_next = ST_RESP;
      ST_RESP: if (r_resp_valid && resp_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = r_resp_valid;
    resp_rdata = r_resp_rdata;
    resp_error = r_resp_error;
    mmio_valid = r_mmio_valid;
    mmio_addr  = r_mmio_addr;
    mmio_wdata = r_mmio_wdata;
  end

  // The old word is read at acceptance so the merge is ready by RESP.
  always_ff @(posedge clk) begin
    if (w_accept) r_rd_word <= r_mem[req_addr[IDX_W+1:2]];
    if (w_commit) r_mem[r_addr[IDX_W+1:2]] <= w_merged;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_error <= 1'b0;
      r_mmio_valid <= 1'b0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
    end else begin
      r_mmio_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_write  <= req_write;
            r_cnt    <= LAT;
          end
        end
        ST_WAIT: r_cnt <= r_cnt - 4'd1;
        ST_RESP: begin
          if (!r_resp_valid) begin
            r_resp_valid <= 1'b1;
            r_resp_error <= w_err;
            r_resp_rdata <= (r_write || w_err || w_is_mmio) ? 32'd0 : w_load_data;
            if (r_write && w_is_mmio && !w_err) begin
              r_mmio_valid <= 1'b1;
              r_mmio_addr  <= r_addr;
              r_mmio_wdata <= r_wdata;
            end
          end else if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: a byte-array reference model predicts
// every response and MMIO strobe; monitors pop and compare independently.
module tb_ram_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mmio_valid;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;

  ram_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .MMIO_BASE(32'h0001_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .mmio_valid (mmio_valid),
    .mmio_addr  (mmio_addr),
    .mmio_wdata (mmio_wdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] mq[$];
  logic [7:0]  mem_b [DEPTH*4];
  int          stall_next = -1;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: little-endian byte memory, sizes 1/2/4, plain sign extension.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [2:0] f3, input int acc);
    exp_t        e;
    int          size;
    logic        legal;
    logic        mmio;
    logic [31:0] v;
    size  = 1 << f3[1:0];
    legal = w ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    mmio  = (a >= 32'h0001_0000);
    e.acc   = acc;
    e.rdata = 32'd0;
    e.err   = !legal || ((a % size) != 0) || (!mmio && (a / 4) >= DEPTH);
    if (e.err) return e;
    if (mmio) begin
      if (w) mq.push_back({a, d});
      return e;
    end
    if (w) begin
      for (int i = 0; i < size; i++) mem_b[int'(a) + i] = d[8*i +: 8];
      return e;
    end
    v = 32'd0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = mem_b[int'(a) + i];
    if (!f3[2] && size < 4 && v[8*size-1])
      for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
    e.rdata = v;
    return e;
  endfunction

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit abort = 1'b0);
    int n = 0;
    @(negedge clk);
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_funct3 = f3;
    req_valid  = 1'b1;
    while (!req_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    $display("req %s addr=%h wdata=%h f3=%0d%s", w ? "ST" : "LD", a, d, f3, abort ? " (aborted)" : "");
    if (abort) begin
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_req_ready", 32'(req_ready), 32'd1);
      chk("abort_resp_valid", 32'(resp_valid), 32'd0);
      chk("abort_resp_rdata", resp_rdata, 32'd0);
      chk("abort_resp_error", 32'(resp_error), 32'd0);
      chk("abort_mmio_valid", 32'(mmio_valid), 32'd0);
      chk("abort_mmio_addr", mmio_addr, 32'd0);
      chk("abort_mmio_wdata", mmio_wdata, 32'd0);
    end else begin
      sb.push_back(model(w, a, d, f3, cyc));
    end
  endtask

  // Response monitor: checks latency and data, stalls, then handshakes.
  initial begin : resp_mon
    exp_t        e;
    logic [31:0] snap_d;
    logic        snap_e;
    int          n;
    forever begin
      @(negedge clk);
      if (resp_valid && !rst) begin
        chk("resp_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("latency", 32'(cyc - e.acc), 32'(LAT + 1));
          chk("rdata", resp_rdata, e.rdata);
          chk("error", 32'(resp_error), 32'(e.err));
          $display("resp rdata=%h err=%0d (want %h/%0d)", resp_rdata, resp_error, e.rdata, e.err);
        end
        snap_d = resp_rdata;
        snap_e = resp_error;
        n = (stall_next >= 0) ? stall_next : $urandom_range(0, 2);
        stall_next = -1;
        repeat (n) begin
          @(negedge clk);
          chk("hold_valid", 32'(resp_valid), 32'd1);
          chk("hold_rdata", resp_rdata, snap_d);
          chk("hold_error", 32'(resp_error), 32'(snap_e));
          chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_req_ready", 32'(req_ready), 32'd1);
        chk("idle_after_resp_valid", 32'(resp_valid), 32'd0);
      end
    end
  end

  // MMIO monitor: every strobe cycle must match one predicted MMIO store.
  initial begin : mmio_mon
    logic [63:0] m;
    forever begin
      @(negedge clk);
      if (mmio_valid && !rst) begin
        chk("mmio_strobe_expected", 32'(mmio_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
          m = mq.pop_front();
          chk("mmio_addr", mmio_addr, m[63:32]);
          chk("mmio_wdata", mmio_wdata, m[31:0]);
          $display("mmio addr=%h wdata=%h", mmio_addr, mmio_wdata);
        end
      end
    end
  end

  initial begin : stim
    int          n;
    int          r;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(resp_error), 32'd0);
    chk("rst_mmio_valid", 32'(mmio_valid), 32'd0);
    chk("rst_mmio_addr", mmio_addr, 32'd0);
    chk("rst_mmio_wdata", mmio_wdata, 32'd0);
    rst = 1'b0;

    issue(1, 32'h10, 32'hDEADBEEF, 3'd2);
    issue(0, 32'h10, 32'h0, 3'd2);
    issue(1, 32'h11, 32'h7F, 3'd0);
    issue(0, 32'h11, 32'h0, 3'd0);
    issue(0, 32'h13, 32'h0, 3'd4);
    issue(0, 32'h12, 32'h0, 3'd1);
    issue(0, 32'h10, 32'h0, 3'd2);
    issue(1, 32'h4, 32'h0BADF00D, 3'd2);
    issue(0, 32'h2, 32'h0, 3'd2);
    issue(1, 32'h5, 32'hFFFF, 3'd1);
    issue(0, 32'(DEPTH*4), 32'h0, 3'd2);
    issue(0, 32'h4, 32'h0, 3'd2);
    issue(1, 32'h10, 32'h1, 3'd4);
    issue(0, 32'h10, 32'h0, 3'd3);
    issue(0, 32'h10, 32'h0, 3'd2);
    issue(1, 32'h0001_0004, 32'h41, 3'd2);
    issue(0, 32'h0001_0004, 32'h0, 3'd2);
    stall_next = 5;
    issue(0, 32'h10, 32'h0, 3'd2);
    issue(1, 32'h20, 32'hCAFEF00D, 3'd2);
    issue(1, 32'h20, 32'h12345678, 3'd2, 1'b1);
    issue(0, 32'h20, 32'h0, 3'd2);

    repeat (150) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = 32'($urandom_range(0, 63));
      else if (r < 8) a = 32'(DEPTH*4 - 8) + 32'($urandom_range(0, 15));
      else            a = 32'h0000_FFFC + 32'($urandom_range(0, 11));
      f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      issue(1'($urandom_range(0, 1)), a, $urandom, f3);
    end

    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("mmio_drained", 32'(mq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
